mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port of the MIPS core between the instruction-fetch path and the load/store path. One transaction is outstanding at a time. Data accesses win by default, and a starvation guard periodically forces a fetch through. A watchdog completes any memory transaction that never returns, so a broken memory model cannot hang the simulation.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending; 0 = pure data priority; max 15
- TIMEOUT, 1024: cycles a transaction may stay in MREQ+MWAIT before forced completion
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-low; clock clk
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  32  fetch byte address (word aligned)
- i_ack  out  1  one-cycle fetch completion
- i_rdata  out  32  fetch data, valid with i_ack
- d_req  in  1  data request; held with payload until d_ack
- d_we  in  1  1 = store
- d_be  in  4  byte enables for stores
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle data completion (loads and stores)
- d_rdata  out  32  load data, valid with d_ack
- m_req  out  1  memory request
- m_we, m_be, m_addr, m_wdata  out  1/4/32/32  latched payload
- m_ready  in  1  memory accepts m_req this cycle
- m_rvalid  in  1  memory completion (reads and writes)
- m_rdata  in  32  read data, valid with m_rvalid
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, MREQ, MWAIT, ACK.
- IDLE: sample requests.
  - If d_req and (i_req==0 or STARVE_LIMIT==0 or streak<STARVE_LIMIT), grant data.
  - Otherwise, if i_req, grant fetch.
  - On grant, latch payload and owner, then go to MREQ.
  - A fetch payload latches we=0, be=4'hF, wdata=0.
- MREQ: m_req=1 with the latched payload. When m_ready=1, go to MWAIT.
- MWAIT: m_req=0. When m_rvalid=1, register m_rdata into the owner's rdata and go to ACK.
- ACK: pulse the owner's ack for one cycle, then return to IDLE. Requests are ignored in ACK, so a req still high at the ack edge is never re-granted.
- streak counter (4 bit):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant.
  - Clears on a data grant with i_req=0.
  - Saturates at 15.
- Watchdog counter:
  - Clears on every grant and counts in MREQ and MWAIT.
  - At TIMEOUT, go to ACK with rdata=32'hDEADBEEF and set err.
  - m_req drops and any later m_rvalid is ignored.
- Stray inputs: m_rvalid outside MWAIT and m_ready outside MREQ are ignored.
- Reset:
  - All outputs 0, err=0, streak=0, watchdog=0, state IDLE.
  - Reset mid-transaction abandons the transaction with no ack.

## Timing
- Example: req sampled at edge E0. m_req is high from E0 to E1. With m_ready=1 at E1, the state is MWAIT. With m_rvalid at E2, the ack cycle runs E2–E3. The state is IDLE after E3.
- Minimum service time is 4 cycles from request to the next possible grant.
- Earliest m_rvalid is the cycle after acceptance. An m_rvalid in the same cycle as m_ready is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Only one ack is ever asserted, never both, and only in ACK.

## Structure
- Package mips_mem_pkg holds:
  - the state enum (IDLE, MREQ, MWAIT, ACK),
  - the owner encoding (OWN_I, OWN_D),
  - ERR_RDATA = 32'hDEADBEEF,
  - the width constants.
- Single module with no sub-modules. The grant decision stays an inline combinational block.

## Test plan
- **Lone fetch:** i_req with i_addr=0x0000_0040, memory ready at once, rvalid 1 cycle later with rdata 0x2408_0005. Expect i_ack one cycle later, i_rdata=0x2408_0005, m_we=0, m_be=F.
- **Simultaneous requests:** i_req and d_req together, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xCAFE_BABE. Expect the data is granted first with m_be=3, and the fetch is granted only after d_ack.
- **Starvation guard:** STARVE_LIMIT=2, d_req held continuously, i_req held. Expect the grant order D, D, I, D, D, I.
- **Stall:** m_ready low for 5 cycles. Expect m_req and the payload held stable and no ack; after acceptance, normal completion.
- **Timeout:** TIMEOUT=16, m_rvalid never arrives. Expect d_ack with d_rdata=0xDEADBEEF and err=1 held until reset; a later stray m_rvalid is ignored.
- **Reset mid-transaction:** rst=0 in MWAIT. Expect all outputs 0, no ack, err=0, and the next request is served normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_mem_pkg : shared types and constants for the unified memory port
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MREQ  = 2'd1,
    MWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and load/store
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [BE_W-1:0]   m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int                  WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  state_t              r_state;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [WD_W-1:0]     r_wd;

  logic w_grant_d;
  logic w_grant_i;
  logic w_rsp;
  logic w_timeout;

  // A real response in the last watchdog cycle wins over the forced completion.
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_rsp     = (r_state == MWAIT) && m_rvalid;
    w_timeout = ((r_state == MREQ) || (r_state == MWAIT)) && (r_wd == WD_LAST) && !w_rsp;
    if (r_state == IDLE) begin
      if (d_req && (!i_req || (STARVE_LIMIT == 0) || (r_streak < STREAK_CAP))) begin
        w_grant_d = 1'b1;
      end else if (i_req) begin
        w_grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= OWN_I;
      r_streak <= '0;
      r_wd     <= '0;
      i_ack    <= 1'b0;
      i_rdata  <= '0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      err      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_owner <= OWN_D;
            m_we    <= d_we;
            m_be    <= d_be;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (!i_req) begin
              r_streak <= '0;
            end else if (r_streak != STREAK_MAX) begin
              r_streak <= r_streak + 1'b1;
            end
          end else if (w_grant_i) begin
            r_owner  <= OWN_I;
            m_we     <= 1'b0;
            m_be     <= 4'hF;
            m_addr   <= i_addr;
            m_wdata  <= '0;
            r_streak <= '0;
          end
          if (w_grant_d || w_grant_i) begin
            m_req   <= 1'b1;
            r_wd    <= '0;
            r_state <= MREQ;
          end
        end
        MREQ: begin
          r_wd <= r_wd + 1'b1;
          if (m_ready) begin
            m_req   <= 1'b0;
            r_state <= MWAIT;
          end
        end
        MWAIT: r_wd <= r_wd + 1'b1;
        ACK:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_rsp || w_timeout) begin
        m_req   <= 1'b0;
        r_state <= ACK;
        if (r_owner == OWN_D) begin
          d_ack   <= 1'b1;
          d_rdata <= w_rsp ? m_rdata : ERR_RDATA;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= w_rsp ? m_rdata : ERR_RDATA;
        end
        if (w_timeout) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : randomized scoreboard bench for mem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int          SL        = 2;
  localparam int          TO        = 16;
  localparam logic [31:0] DROP_ADDR = 32'h0000_01F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        err;

  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
  } cmd_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          to;
  } exp_t;

  cmd_t fcmd[$];
  cmd_t dcmd[$];
  exp_t fq[$];
  exp_t dq[$];
  bit   glog[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem     [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int last_lat = 0;
  int force_stall = -1;
  int force_dly = -1;
  bit busy_f = 0, busy_d = 0, kill = 0, stray = 0, rv_pend = 0, drop_wait = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h2408_0005;
    return {~a[15:0], a[15:0]} ^ 32'h3C1A_0000;
  endfunction

  // Reference model: fetches read pristine memory; data ops see all earlier stores.
  task automatic issue_d(input cmd_t c);
    exp_t        e;
    logic [31:0] w;
    e.addr = c.addr; e.we = c.we; e.be = c.be; e.wdata = c.wdata;
    e.to   = (c.addr == DROP_ADDR);
    w = ref_mem.exists(c.addr) ? ref_mem[c.addr] : init_word(c.addr);
    if (e.to) begin
      e.rdata = 32'hDEADBEEF;
    end else if (c.we) begin
      e.rdata = {16'h5709, c.addr[15:0]};
      for (int i = 0; i < 4; i++) if (c.be[i]) w[8*i +: 8] = c.wdata[8*i +: 8];
      ref_mem[c.addr] = w;
    end else begin
      e.rdata = w;
    end
    dq.push_back(e);
  endtask

  task automatic issue_f(input cmd_t c);
    exp_t e;
    e.addr = c.addr; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0;
    e.rdata = init_word(c.addr); e.to = 1'b0;
    fq.push_back(e);
  endtask

  task automatic push_f(input logic [31:0] a, input int gap);
    cmd_t c;
    c.we = 1'b0; c.be = 4'hF; c.addr = a; c.wdata = 32'h0; c.gap = gap;
    fcmd.push_back(c);
  endtask

  task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input int gap);
    cmd_t c;
    c.we = we; c.be = be; c.addr = a; c.wdata = wd; c.gap = gap;
    dcmd.push_back(c);
  endtask

  // Fetch requester
  initial begin : drv_f
    cmd_t c;
    int idle = 0;
    int waitc = 0;
    i_req = 1'b0; i_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (kill) begin
        i_req = 1'b0; busy_f = 0; fcmd.delete(); idle = 0;
      end else begin
        if (busy_f) begin
          if (i_ack) busy_f = 0;
          else begin
            waitc++;
            if (waitc > 300) begin fail("fetch_ack_timeout"); busy_f = 0; end
          end
        end
        if (!busy_f) begin
          if (fcmd.size() > 0 && idle >= fcmd[0].gap) begin
            c = fcmd.pop_front();
            i_req = 1'b1; i_addr = c.addr;
            issue_f(c);
            busy_f = 1; waitc = 0; idle = 0;
          end else begin
            i_req = 1'b0; idle++;
          end
        end
      end
    end
  end

  // Load/store requester
  initial begin : drv_d
    cmd_t c;
    int idle = 0;
    int waitc = 0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (kill) begin
        d_req = 1'b0; busy_d = 0; dcmd.delete(); idle = 0;
      end else begin
        if (busy_d) begin
          if (d_ack) busy_d = 0;
          else begin
            waitc++;
            if (waitc > 300) begin fail("data_ack_timeout"); busy_d = 0; end
          end
        end
        if (!busy_d) begin
          if (dcmd.size() > 0 && idle >= dcmd[0].gap) begin
            c = dcmd.pop_front();
            d_req = 1'b1; d_we = c.we; d_be = c.be; d_addr = c.addr; d_wdata = c.wdata;
            issue_d(c);
            busy_d = 1; waitc = 0; idle = 0;
          end else begin
            d_req = 1'b0; idle++;
          end
        end
      end
    end
  end

  // Memory model with random stalls, latencies and stray handshakes
  initial begin : responder
    bit          in_req = 0;
    bit          prev_acc = 0;
    int          stall_left = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_data = 32'h0;
    logic [31:0] w;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_req = 0; prev_acc = 0; rv_pend = 0; drop_wait = 0;
        m_ready = 1'b0; m_rvalid = 1'b0;
      end else begin
        m_rvalid = 1'b0;
        if (d_ack) drop_wait = 0;
        if (prev_acc) begin
          in_req = 0;
          if (m_addr == DROP_ADDR) begin
            drop_wait = 1;
          end else begin
            w = mem.exists(m_addr) ? mem[m_addr] : init_word(m_addr);
            if (m_we) begin
              for (int i = 0; i < 4; i++) if (m_be[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
              mem[m_addr] = w;
              rv_data = {16'h5709, m_addr[15:0]};
            end else begin
              rv_data = w;
            end
            rv_cnt  = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
            rv_pend = 1;
          end
        end
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            m_rvalid = 1'b1; m_rdata = rv_data; rv_pend = 0;
          end else begin
            rv_cnt--;
          end
        end else if (stray || (!drop_wait && $urandom_range(0, 7) == 0)) begin
          m_rvalid = 1'b1; m_rdata = $urandom; stray = 0;
        end
        if (m_req) begin
          if (!in_req) begin
            in_req = 1;
            stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          end
          m_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else begin
          m_ready = ($urandom_range(0, 1) == 1);
        end
        prev_acc = m_ready && m_req;
      end
    end
  end

  // Monitor: grant order, payload, completion data, latency and err
  initial begin : monitor
    bit   prev_mreq = 0, p_ireq = 0, p_dreq = 0, cur_own = 0, in_txn = 0, err_model = 0;
    bit   own, exp_own;
    int   streak = 0;
    int   lat = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_mreq = 0; streak = 0; in_txn = 0; err_model = 0;
      end else begin
        if (in_txn) lat++;
        if (m_req && !prev_mreq) begin
          own     = (m_addr >= 32'h100);
          exp_own = (p_dreq && (!p_ireq || streak < SL));
          chk("grant_owner", {31'b0, own}, {31'b0, exp_own});
          chk("grant_requested", {31'b0, own ? p_dreq : p_ireq}, 32'd1);
          glog.push_back(own);
          if (own) streak = p_ireq ? ((streak < 15) ? streak + 1 : 15) : 0;
          else     streak = 0;
          cur_own = own; in_txn = 1; lat = 0;
        end
        if (m_req) begin
          if ((cur_own && dq.size() == 0) || (!cur_own && fq.size() == 0)) begin
            fail("grant_unexpected");
          end else begin
            e = cur_own ? dq[0] : fq[0];
            chk("m_addr",  m_addr, e.addr);
            chk("m_we",    {31'b0, m_we}, {31'b0, e.we});
            chk("m_be",    {28'b0, m_be}, {28'b0, e.be});
            chk("m_wdata", m_wdata, e.wdata);
          end
        end
        if (i_ack || d_ack) begin
          own = d_ack;
          chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'd0);
          if (!in_txn) fail("ack_without_grant");
          else chk("ack_owner", {31'b0, own}, {31'b0, cur_own});
          if ((own && dq.size() == 0) || (!own && fq.size() == 0)) begin
            fail("ack_unexpected");
          end else begin
            e = own ? dq.pop_front() : fq.pop_front();
            chk(own ? "d_rdata" : "i_rdata", own ? d_rdata : i_rdata, e.rdata);
            if (e.to) begin
              chk("timeout_latency", 32'(lat), 32'(TO));
              chk("timeout_err", {31'b0, err}, 32'd1);
              err_model = 1;
            end else begin
              chk("ack_err", {31'b0, err}, {31'b0, err_model});
            end
          end
          last_lat = lat; in_txn = 0;
        end
        prev_mreq = m_req;
      end
      p_ireq = i_req; p_dreq = d_req;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((fcmd.size() > 0 || dcmd.size() > 0 || busy_f || busy_d) && n < 3000) begin
      @(posedge clk); n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(n), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_req"},   {31'b0, m_req}, 32'd0);
    chk({tag, "_i_ack"},   {31'b0, i_ack}, 32'd0);
    chk({tag, "_d_ack"},   {31'b0, d_ack}, 32'd0);
    chk({tag, "_err"},     {31'b0, err}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_m_addr"},  m_addr, 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_m_we_be"}, {27'b0, m_we, m_be}, 32'd0);
  endtask

  initial begin : main
    bit exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Lone fetch with an immediately ready memory
    force_stall = 0; force_dly = 0; glog.delete();
    @(negedge clk); push_f(32'h40, 0);
    wait_idle();
    chk("lone_grants", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) chk("lone_owner", {31'b0, glog[0]}, 32'd0);
    chk("lone_latency", 32'(last_lat), 32'd2);
    chk("lone_i_rdata", i_rdata, 32'h2408_0005);

    // Simultaneous requests: data first, then fetch
    force_stall = -1; force_dly = -1; glog.delete();
    @(negedge clk);
    push_d(1'b1, 4'b0011, 32'h100, 32'hCAFE_BABE, 0);
    push_f(32'h44, 0);
    wait_idle();
    chk("simul_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("simul_first",  {31'b0, glog[0]}, 32'd1);
      chk("simul_second", {31'b0, glog[1]}, 32'd0);
    end
    @(negedge clk); push_d(1'b0, 4'hF, 32'h100, 32'h0, 0);
    wait_idle();

    // Starvation guard
    glog.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                                       32'h100 + 32'(4 * $urandom_range(0, 59)), $urandom, 0);
    push_f(32'h80, 0);
    push_f(32'h84, 0);
    wait_idle();
    chk("starve_grants", 32'(glog.size()), 32'd6);
    if (glog.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("starve_order", {31'b0, glog[i]}, {31'b0, exp_order[i]});
    end

    // Stall: five cycles without m_ready
    force_stall = 5; force_dly = 0;
    @(negedge clk); push_f(32'h48, 0);
    wait_idle();
    chk("stall_latency", 32'(last_lat), 32'd7);

    // Timeout: memory never answers
    force_stall = -1; force_dly = -1;
    @(negedge clk); push_d(1'b0, 4'hF, DROP_ADDR, 32'h1234_5678, 0);
    wait_idle();
    chk("timeout_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("timeout_err_set", {31'b0, err}, 32'd1);
    @(negedge clk); stray = 1;
    repeat (4) @(posedge clk);
    #1 chk("err_sticky", {31'b0, err}, 32'd1);

    // Randomized mix
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      push_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
             32'h100 + 32'(4 * $urandom_range(0, 59)), $urandom, int'($urandom_range(0, 3)));
      push_f(32'(4 * $urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("err_still_sticky", {31'b0, err}, 32'd1);

    // Reset while waiting for the memory response
    force_stall = 0; force_dly = 3;
    @(negedge clk); push_d(1'b0, 4'hF, 32'h104, 32'h0, 0);
    n = 0;
    while (!rv_pend && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("mwait_reach_timeout", 32'(n), 32'd0);
    rst = 1'b0; kill = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("midreset");
    fq.delete(); dq.delete();
    @(posedge clk); #1 kill = 0;
    @(posedge clk); #1 rst = 1'b1;
    force_stall = -1; force_dly = -1;

    @(negedge clk);
    push_f(32'h4C, 0);
    push_d(1'b1, 4'hF, 32'h108, 32'h0BAD_F00D, 0);
    wait_idle();
    @(negedge clk); push_d(1'b0, 4'hF, 32'h108, 32'h0, 1);
    wait_idle();
    chk("post_reset_d_rdata", d_rdata, 32'h0BAD_F00D);
    chk("post_reset_err", {31'b0, err}, 32'd0);
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
